// File: rtl/msrv32_dmem_responder.sv
// msrv32_dmem_responder
//   Data-side memory slave for the core's store/load interface. Accepts
//   word-aligned requests with byte-lane write masks, inserts WAIT_STATES
//   wait cycles, then performs a masked write or a whole-word read on an
//   internal word array. Out-of-range indices give an AHB two-cycle error.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (valid index 0..DEPTH_WORDS-1)
//   WAIT_STATES : wait cycles per access, 0..7
//
// Ports
//   ms_riscv32_mp_clk_in       : clock, rising edge
//   ms_riscv32_mp_rst_in       : asynchronous active-low reset
//   ms_riscv32_mp_dmaddr_in    : byte address, word index = [31:2]
//   ms_riscv32_mp_dmdata_in    : lane-aligned store data
//   ms_riscv32_mp_dmwr_mask_in : byte-lane write enables
//   ms_riscv32_mp_dmwr_req_in  : write request (wins over read)
//   ms_riscv32_mp_dmrd_req_in  : read request
//   ahb_htrans_in              : transfer type, NONSEQ/SEQ start a request
//   ahb_ready_out              : request can be accepted / access completes
//   ahb_resp_out               : error response (two cycles)
//   ms_riscv32_mp_dmdata_out   : read data, held until the next read
//   ms_riscv32_mp_rdvalid_out  : one-cycle strobe qualifying read data
module msrv32_dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        ms_riscv32_mp_clk_in,
   input  logic        ms_riscv32_mp_rst_in,
   input  logic [31:0] ms_riscv32_mp_dmaddr_in,
   input  logic [31:0] ms_riscv32_mp_dmdata_in,
   input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
   input  logic        ms_riscv32_mp_dmwr_req_in,
   input  logic        ms_riscv32_mp_dmrd_req_in,
   input  logic [1:0]  ahb_htrans_in,
   output logic        ahb_ready_out,
   output logic        ahb_resp_out,
   output logic [31:0] ms_riscv32_mp_dmdata_out,
   output logic        ms_riscv32_mp_rdvalid_out
);

   localparam int         IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [2:0] WAIT_LD = 3'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_ERR
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [2:0]  cnt_q;
   logic [29:0] widx_q;
   logic [31:0] wdata_q;
   logic [3:0]  mask_q;
   logic        wr_q;
   logic        err_tail_q;
   logic [31:0] rdata_q;
   logic        rdvalid_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic             accept;
   logic             capture;
   logic             access;
   logic             in_range;
   logic [IDX_W-1:0] mem_idx;
   logic             unused_bits;

   // Address lane bits and the SEQ/NONSEQ distinction carry no meaning here.
   assign unused_bits = ^{ahb_htrans_in[0], ms_riscv32_mp_dmaddr_in[1:0]};

   assign access   = (state_q == S_BUSY) && (cnt_q == '0);
   assign in_range = ({2'b00, widx_q} < 32'(DEPTH_WORDS));
   assign mem_idx  = widx_q[IDX_W-1:0];
   assign accept   = ahb_ready_out && ahb_htrans_in[1] &&
                     (ms_riscv32_mp_dmwr_req_in || ms_riscv32_mp_dmrd_req_in);
   // An access edge that raises the error does not take a new request,
   // even though ready is high in that cycle.
   assign capture  = accept && !(access && !in_range);

   // State register
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_BUSY;
         end
         S_BUSY: begin
            if (access) begin
               if (!in_range)   state_d = S_ERR;
               else if (accept) state_d = S_BUSY;
               else             state_d = S_IDLE;
            end
         end
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs; resp stays high for the first IDLE cycle after ERR
   always_comb begin
      ahb_ready_out = 1'b1;
      ahb_resp_out  = err_tail_q;
      case (state_q)
         S_IDLE: ahb_ready_out = 1'b1;
         S_BUSY: ahb_ready_out = (cnt_q == '0);
         S_ERR: begin
            ahb_ready_out = 1'b0;
            ahb_resp_out  = 1'b1;
         end
         default: ahb_ready_out = 1'b1;
      endcase
   end

   // Request capture, wait counter and read return path
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         cnt_q      <= '0;
         widx_q     <= '0;
         wdata_q    <= '0;
         mask_q     <= '0;
         wr_q       <= 1'b0;
         err_tail_q <= 1'b0;
         rdata_q    <= '0;
         rdvalid_q  <= 1'b0;
      end else begin
         err_tail_q <= (state_q == S_ERR);
         rdvalid_q  <= access && !wr_q;

         if (capture) begin
            cnt_q   <= WAIT_LD;
            widx_q  <= ms_riscv32_mp_dmaddr_in[31:2];
            wdata_q <= ms_riscv32_mp_dmdata_in;
            mask_q  <= ms_riscv32_mp_dmwr_mask_in;
            wr_q    <= ms_riscv32_mp_dmwr_req_in;
         end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 3'd1;
         end

         if (access && !wr_q) begin
            rdata_q <= in_range ? mem[mem_idx] : '0;
         end
      end
   end

   // Word array: not reset; a reset during BUSY clears the state so the
   // pending write never reaches its access edge.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (access && wr_q && in_range) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (mask_q[i]) mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign ms_riscv32_mp_dmdata_out  = rdata_q;
   assign ms_riscv32_mp_rdvalid_out = rdvalid_q;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
module tb_msrv32_dmem_responder;

   localparam int DEPTH = 64;
   localparam int WA    = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: one wait state
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [3:0]  a_mask;
   logic        a_wr, a_rd, a_ready, a_resp, a_rdvalid;
   logic [1:0]  a_ht;

   // Instance B: zero wait states
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [3:0]  b_mask;
   logic        b_wr, b_rd, b_ready, b_resp, b_rdvalid;
   logic [1:0]  b_ht;

   msrv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WA)) dut_a (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_in       (rst_n),
      .ms_riscv32_mp_dmaddr_in    (a_addr),
      .ms_riscv32_mp_dmdata_in    (a_wdata),
      .ms_riscv32_mp_dmwr_mask_in (a_mask),
      .ms_riscv32_mp_dmwr_req_in  (a_wr),
      .ms_riscv32_mp_dmrd_req_in  (a_rd),
      .ahb_htrans_in              (a_ht),
      .ahb_ready_out              (a_ready),
      .ahb_resp_out               (a_resp),
      .ms_riscv32_mp_dmdata_out   (a_rdata),
      .ms_riscv32_mp_rdvalid_out  (a_rdvalid)
   );

   msrv32_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
      .ms_riscv32_mp_clk_in       (clk),
      .ms_riscv32_mp_rst_in       (rst_n),
      .ms_riscv32_mp_dmaddr_in    (b_addr),
      .ms_riscv32_mp_dmdata_in    (b_wdata),
      .ms_riscv32_mp_dmwr_mask_in (b_mask),
      .ms_riscv32_mp_dmwr_req_in  (b_wr),
      .ms_riscv32_mp_dmrd_req_in  (b_rd),
      .ahb_htrans_in              (b_ht),
      .ahb_ready_out              (b_ready),
      .ahb_resp_out               (b_resp),
      .ms_riscv32_mp_dmdata_out   (b_rdata),
      .ms_riscv32_mp_rdvalid_out  (b_rdvalid)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] model_a [DEPTH];
   logic [31:0] model_b [DEPTH];
   logic [31:0] a_last = '0;
   logic [31:0] b_last = '0;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [1:0]  ht;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic        isrd;
      logic [31:0] exp;
   } bop_t;
   bop_t bq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
      logic [31:0] bm;
      bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      return (old & ~bm) | (d & bm);
   endfunction

   task automatic idle_a();
      a_ht = 2'b00; a_wr = 1'b0; a_rd = 1'b0;
      a_addr = '0; a_wdata = '0; a_mask = '0;
   endtask

   task automatic idle_b();
      b_ht = 2'b00; b_wr = 1'b0; b_rd = 1'b0;
      b_addr = '0; b_wdata = '0; b_mask = '0;
   endtask

   // One isolated transaction on instance A; the cycle-by-cycle expectation
   // comes from the wait-state count and whether the word index exists.
   task automatic do_a(input logic wr, input logic rd, input logic [1:0] ht,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, output logic [31:0] rd_seen);
      logic acc, isrd, oor;
      logic exp_ready, exp_resp, exp_valid;
      int unsigned idx;
      logic [31:0] exp_rd;
      idx    = int'(addr >> 2);
      acc    = ht[1] && (wr || rd);
      oor    = (idx >= DEPTH);
      isrd   = acc && rd && !wr;
      exp_rd = '0;
      if (isrd && !oor) exp_rd = model_a[idx];
      if (acc && wr && !oor) model_a[idx] = merge(model_a[idx], data, mask);

      @(negedge clk);
      a_ht = ht; a_wr = wr; a_rd = rd; a_addr = addr; a_wdata = data; a_mask = mask;
      @(posedge clk);
      #1 idle_a();
      rd_seen = a_rdata;
      for (int k = 0; k <= WA + 3; k++) begin
         @(negedge clk);
         exp_ready = 1'b1; exp_resp = 1'b0; exp_valid = 1'b0;
         if (acc) begin
            if (k < WA)                  exp_ready = 1'b0;
            else if (k == WA + 1 && oor) exp_ready = 1'b0;
            exp_resp  = oor && (k == WA + 1 || k == WA + 2);
            exp_valid = isrd && (k == WA + 1);
         end
         if (exp_valid) begin
            a_last  = exp_rd;
            rd_seen = a_rdata;
         end
         check("a_ready",   32'(a_ready),   32'(exp_ready));
         check("a_resp",    32'(a_resp),    32'(exp_resp));
         check("a_rdvalid", 32'(a_rdvalid), 32'(exp_valid));
         check("a_rdata",   a_rdata,        a_last);
      end
   endtask

   task automatic b_push(input logic wr, input logic rd, input logic [1:0] ht,
                         input int unsigned idx, input logic [31:0] data,
                         input logic [3:0] mask);
      bop_t op;
      logic acc;
      acc     = ht[1] && (wr || rd);
      op.wr   = wr; op.rd = rd; op.ht = ht;
      op.addr = 32'(idx) << 2;
      op.data = data; op.mask = mask;
      op.isrd = acc && rd && !wr;
      op.exp  = model_b[idx];
      if (acc && wr) model_b[idx] = merge(model_b[idx], data, mask);
      bq.push_back(op);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      logic [31:0] r;
      int unsigned n;

      idle_a();
      idle_b();

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_a_ready",   32'(a_ready),   32'd1);
      check("rst_a_resp",    32'(a_resp),    32'd0);
      check("rst_a_rdata",   a_rdata,        32'h0);
      check("rst_a_rdvalid", 32'(a_rdvalid), 32'd0);
      check("rst_b_ready",   32'(b_ready),   32'd1);
      check("rst_b_rdata",   b_rdata,        32'h0);
      rst_n = 1'b1;

      // Give every word of A a known value
      for (int i = 0; i < DEPTH; i++) begin
         do_a(1'b1, 1'b0, 2'b10, 32'(i) << 2, $urandom, 4'hF, got);
      end

      // Full-word write then read
      do_a(1'b1, 1'b0, 2'b10, 32'h40, 32'h12345678, 4'hF, got);
      do_a(1'b0, 1'b1, 2'b10, 32'h40, 32'h0, 4'h0, got);
      check("full_word", got, 32'h12345678);

      // Byte and halfword lane writes
      do_a(1'b1, 1'b0, 2'b11, 32'h44, 32'h11223344, 4'hF, got);
      do_a(1'b1, 1'b0, 2'b10, 32'h44, 32'h0000AB00, 4'b0010, got);
      do_a(1'b0, 1'b1, 2'b10, 32'h44, 32'h0, 4'h0, got);
      check("byte_lane", got, 32'h1122AB44);
      do_a(1'b1, 1'b0, 2'b10, 32'h44, 32'hCAFE0000, 4'b1100, got);
      do_a(1'b0, 1'b1, 2'b11, 32'h47, 32'h0, 4'h0, got);
      check("half_lane", got, 32'hCAFEAB44);

      // Zero mask leaves the word alone
      do_a(1'b1, 1'b0, 2'b10, 32'h44, 32'hFFFFFFFF, 4'b0000, got);
      do_a(1'b0, 1'b1, 2'b10, 32'h44, 32'h0, 4'h0, got);
      check("mask_zero", got, 32'hCAFEAB44);

      // Out of range write and read; word 0 must not be aliased
      do_a(1'b1, 1'b0, 2'b10, 32'(4 * DEPTH), 32'hA5A5A5A5, 4'hF, got);
      do_a(1'b0, 1'b1, 2'b10, 32'(4 * DEPTH), 32'h0, 4'h0, got);
      check("oor_rdata", got, 32'h0);
      do_a(1'b0, 1'b1, 2'b10, 32'h0, 32'h0, 4'h0, got);

      // IDLE/BUSY transfers are ignored; write beats read when both are high
      do_a(1'b1, 1'b0, 2'b00, 32'h48, 32'h13572468, 4'hF, got);
      do_a(1'b1, 1'b0, 2'b01, 32'h48, 32'h13572468, 4'hF, got);
      do_a(1'b0, 1'b1, 2'b10, 32'h48, 32'h0, 4'h0, got);
      do_a(1'b1, 1'b1, 2'b10, 32'h48, 32'h0F0F0F0F, 4'hF, got);
      do_a(1'b0, 1'b1, 2'b10, 32'h48, 32'h0, 4'h0, got);
      check("wr_and_rd", got, 32'h0F0F0F0F);

      // Reset during the wait of a write discards it
      do_a(1'b1, 1'b0, 2'b10, 32'h10, 32'h0BADF00D, 4'hF, got);
      @(negedge clk);
      a_ht = 2'b10; a_wr = 1'b1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF; a_mask = 4'hF;
      @(posedge clk);
      #1 idle_a();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ready",   32'(a_ready),   32'd1);
      check("midrst_resp",    32'(a_resp),    32'd0);
      check("midrst_rdata",   a_rdata,        32'h0);
      check("midrst_rdvalid", 32'(a_rdvalid), 32'd0);
      a_last = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      do_a(1'b0, 1'b1, 2'b10, 32'h10, 32'h0, 4'h0, got);
      check("midrst_word4", got, 32'h0BADF00D);

      // Random isolated traffic on A, including out-of-range indices
      for (int i = 0; i < 60; i++) begin
         r = $urandom;
         do_a(r[0], r[1], r[3:2], ((32'($urandom_range(0, DEPTH + 3))) << 2) | 32'(r[5:4]),
              $urandom, r[9:6], got);
      end

      // Instance B: zero wait states, back-to-back pipeline
      for (int i = 0; i < 16; i++) b_push(1'b1, 1'b0, 2'b10, i, $urandom, 4'hF);
      b_push(1'b1, 1'b0, 2'b10, 0, 32'hA0A0A0A0, 4'hF);
      b_push(1'b1, 1'b0, 2'b11, 1, 32'hB1B1B1B1, 4'hF);
      b_push(1'b1, 1'b0, 2'b11, 2, 32'hC2C2C2C2, 4'hF);
      b_push(1'b0, 1'b1, 2'b10, 0, 32'h0, 4'h0);
      b_push(1'b0, 1'b1, 2'b11, 1, 32'h0, 4'h0);
      b_push(1'b0, 1'b1, 2'b11, 2, 32'h0, 4'h0);
      b_push(1'b1, 1'b0, 2'b10, 5, 32'h00770000, 4'b0100);
      b_push(1'b0, 1'b1, 2'b10, 5, 32'h0, 4'h0);
      for (int i = 0; i < 50; i++) begin
         r = $urandom;
         b_push(r[0], r[1], r[3:2], $urandom_range(0, 15), $urandom, r[7:4]);
      end

      n = bq.size();
      for (int i = 0; i < int'(n) + 2; i++) begin
         @(negedge clk);
         check("b_ready", 32'(b_ready), 32'd1);
         check("b_resp",  32'(b_resp),  32'd0);
         if (i >= 2) begin
            if (bq[i-2].isrd) b_last = bq[i-2].exp;
            check("b_rdvalid", 32'(b_rdvalid), 32'(bq[i-2].isrd));
            check("b_rdata",   b_rdata,        b_last);
         end
         if (i < int'(n)) begin
            b_ht = bq[i].ht; b_wr = bq[i].wr; b_rd = bq[i].rd;
            b_addr = bq[i].addr; b_wdata = bq[i].data; b_mask = bq[i].mask;
         end else begin
            idle_b();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
